// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/sequencing controller for the 5-stage datapath: load-use
// bubbles, MEM-stage branch flushes, memory-wait freeze with a sticky
// timeout error, and saturating stall/flush event counters.
module hazard_stall_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             Rst_n,
  input  logic [4:0]       IDrs,
  input  logic [4:0]       IDrt,
  input  logic             IDUsesRt,
  input  logic             EXMemRead,
  input  logic [4:0]       EXrd,
  input  logic [1:0]       MEMBranch,
  input  logic             MEMZero,
  input  logic             MEMReq,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             EXMEMFlush,
  output logic             EXMEMWrite,
  output logic             PCSrc,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int unsigned WCNT_W = 16;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               timeout_q;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   flush_q, flush_d;

  logic memwait_c, taken_c, loaduse_c;
  logic stall_ev_c, flush_ev_c;

  // Hazard conditions decoded from the pipeline stage fields.
  always_comb begin
    memwait_c = MEMReq & ~MemReady;
    taken_c   = ((MEMBranch == 2'b01) &  MEMZero) |
                ((MEMBranch == 2'b10) & ~MEMZero) |
                 (MEMBranch == 2'b11);
    loaduse_c = EXMemRead & (EXrd != 5'd0) &
                ((EXrd == IDrs) | (IDUsesRt & (EXrd == IDrt)));
  end

  // Next-state logic and Mealy pipeline controls; memwait > taken > loaduse.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    EXMEMWrite = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXFlush  = 1'b0;
    EXMEMFlush = 1'b0;
    PCSrc      = 1'b0;
    stall_ev_c = 1'b0;
    flush_ev_c = 1'b0;

    case (state_q)
      S_RUN, S_WAIT: begin
        if (memwait_c) begin
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          EXMEMWrite = 1'b0;
          stall_ev_c = 1'b1;
        end else if (taken_c) begin
          PCSrc      = 1'b1;
          IFIDFlush  = 1'b1;
          IDEXFlush  = 1'b1;
          EXMEMFlush = 1'b1;
          flush_ev_c = 1'b1;
        end else if (loaduse_c) begin
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEXFlush  = 1'b1;
          stall_ev_c = 1'b1;
        end

        if (state_q == S_RUN) begin
          // The entry cycle is wait cycle 1; WAIT's first cycle holds count 0.
          if (memwait_c) begin
            wcnt_d  = '0;
            state_d = (TIMEOUT <= 1) ? S_ERR : S_WAIT;
          end
        end else begin
          if (!memwait_c) begin
            state_d = S_RUN;
          end else if (wcnt_q >= WCNT_W'(TIMEOUT - 2)) begin
            state_d = S_ERR;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      end

      S_ERR: begin
        PCWrite    = 1'b0;
        IFIDWrite  = 1'b0;
        EXMEMWrite = 1'b0;
      end

      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // Saturating event counters; events never fire in ERR.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_ev_c && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (flush_ev_c && (flush_q != {CNT_W{1'b1}})) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  // State, wait counter, error flag and event counters.
  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      state_q   <= S_RUN;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= (state_d == S_ERR);
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign MemTimeout = timeout_q;
  assign StallCount = stall_q;
  assign FlushCount = flush_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the controller.
module tb_hazard_stall_ctrl;

  localparam int unsigned TO   = 4;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = 15;

  // Control vector order: {PCWrite,IFIDWrite,IFIDFlush,IDEXFlush,EXMEMFlush,EXMEMWrite,PCSrc}
  localparam logic [6:0] C_IDLE   = 7'b1100010;
  localparam logic [6:0] C_LU     = 7'b0001010;
  localparam logic [6:0] C_FLUSH  = 7'b1111111;
  localparam logic [6:0] C_FREEZE = 7'b0000000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    id_rs, id_rt, ex_rd;
  logic          id_uses_rt, ex_mem_read, mem_zero, mem_req, mem_ready;
  logic [1:0]    mem_branch;
  logic          pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, exmem_write, pc_src;
  logic          mem_timeout;
  logic [CW-1:0] stall_count, flush_count;
  logic [6:0]    ctrl;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int m_err, m_run, m_stall, m_flush;

  hazard_stall_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk        (clk),
    .Rst_n      (rst_n),
    .IDrs       (id_rs),
    .IDrt       (id_rt),
    .IDUsesRt   (id_uses_rt),
    .EXMemRead  (ex_mem_read),
    .EXrd       (ex_rd),
    .MEMBranch  (mem_branch),
    .MEMZero    (mem_zero),
    .MEMReq     (mem_req),
    .MemReady   (mem_ready),
    .PCWrite    (pc_write),
    .IFIDWrite  (ifid_write),
    .IFIDFlush  (ifid_flush),
    .IDEXFlush  (idex_flush),
    .EXMEMFlush (exmem_flush),
    .EXMEMWrite (exmem_write),
    .PCSrc      (pc_src),
    .MemTimeout (mem_timeout),
    .StallCount (stall_count),
    .FlushCount (flush_count)
  );

  always #5 clk = ~clk;

  assign ctrl = {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, exmem_write, pc_src};

  function automatic int is_memwait();
    return (mem_req && !mem_ready) ? 1 : 0;
  endfunction

  function automatic int is_taken();
    return ((mem_branch == 2'd1 && mem_zero) || (mem_branch == 2'd2 && !mem_zero) ||
            (mem_branch == 2'd3)) ? 1 : 0;
  endfunction

  function automatic int is_loaduse();
    return (ex_mem_read && ex_rd != 0 &&
            (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt))) ? 1 : 0;
  endfunction

  // Expected controls for the current inputs and model state.
  function automatic logic [6:0] exp_ctrl();
    if (m_err != 0)        return C_FREEZE;
    if (is_memwait() != 0) return C_FREEZE;
    if (is_taken() != 0)   return C_FLUSH;
    if (is_loaduse() != 0) return C_LU;
    return C_IDLE;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    if (!rst_n) begin
      m_err = 0; m_run = 0; m_stall = 0; m_flush = 0;
    end else if (m_err == 0) begin
      if (is_memwait() != 0) begin
        m_run++;
        if (m_stall < CMAX) m_stall++;
        if (m_run >= TO) m_err = 1;
      end else begin
        m_run = 0;
        if (is_taken() != 0) begin
          if (m_flush < CMAX) m_flush++;
        end else if (is_loaduse() != 0) begin
          if (m_stall < CMAX) m_stall++;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd1; id_rt = 5'd2; ex_rd = 5'd0;
    id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    mem_branch = 2'd0; mem_zero = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if (ctrl !== C_IDLE) begin
      bad++; $display("FAIL reset_ctrl got=%b want=%b", ctrl, C_IDLE);
    end
    total++;
    if (stall_count !== 4'd0 || flush_count !== 4'd0 || mem_timeout !== 1'b0) begin
      bad++; $display("FAIL reset_regs got stall=%0d flush=%0d to=%b want 0 0 0",
                      stall_count, flush_count, mem_timeout);
    end
    tick();
  endtask

  task automatic test_loaduse();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
    #1;
    total++;
    if (ctrl !== C_LU) begin
      bad++; $display("FAIL loaduse_rs got=%b want=%b", ctrl, C_LU);
    end
    tick();
    ex_mem_read = 1'b0;
    #1;
    total++;
    if (ctrl !== C_IDLE || stall_count !== 4'd1) begin
      bad++; $display("FAIL loaduse_clear got ctrl=%b stall=%0d want ctrl=%b stall=1",
                      ctrl, stall_count, C_IDLE);
    end
    tick();
    // Register $0 never stalls.
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
    #1;
    total++;
    if (ctrl !== C_IDLE) begin
      bad++; $display("FAIL loaduse_r0 got=%b want=%b", ctrl, C_IDLE);
    end
    tick();
    // rt match only matters when the ID instruction reads rt.
    ex_rd = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b0;
    #1;
    total++;
    if (ctrl !== C_IDLE) begin
      bad++; $display("FAIL loaduse_rt_unused got=%b want=%b", ctrl, C_IDLE);
    end
    tick();
    id_uses_rt = 1'b1;
    #1;
    total++;
    if (ctrl !== C_LU) begin
      bad++; $display("FAIL loaduse_rt got=%b want=%b", ctrl, C_LU);
    end
    tick();
    idle();
    #1;
    total++;
    if (stall_count !== 4'd2) begin
      bad++; $display("FAIL loaduse_count got=%0d want=2", stall_count);
    end
  endtask

  task automatic test_branch();
    do_reset();
    mem_branch = 2'd1; mem_zero = 1'b1;
    #1;
    total++;
    if (ctrl !== C_FLUSH) begin
      bad++; $display("FAIL beq_taken got=%b want=%b", ctrl, C_FLUSH);
    end
    tick();
    mem_branch = 2'd2; mem_zero = 1'b1;
    #1;
    total++;
    if (ctrl !== C_IDLE || flush_count !== 4'd1) begin
      bad++; $display("FAIL bne_not_taken got ctrl=%b flush=%0d want ctrl=%b flush=1",
                      ctrl, flush_count, C_IDLE);
    end
    tick();
    // Taken branch together with a load-use: the flush wins, no stall counted.
    mem_branch = 2'd2; mem_zero = 1'b0;
    ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs = 5'd4;
    #1;
    total++;
    if (ctrl !== C_FLUSH) begin
      bad++; $display("FAIL taken_vs_loaduse got=%b want=%b", ctrl, C_FLUSH);
    end
    tick();
    idle();
    #1;
    total++;
    if (flush_count !== 4'd2 || stall_count !== 4'd0) begin
      bad++; $display("FAIL taken_vs_loaduse_cnt got flush=%0d stall=%0d want 2 0",
                      flush_count, stall_count);
    end
  endtask

  task automatic test_memwait();
    do_reset();
    mem_branch = 2'd3; mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (ctrl !== C_FREEZE) begin
        bad++; $display("FAIL memwait_freeze[%0d] got=%b want=%b", i, ctrl, C_FREEZE);
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    total++;
    if (ctrl !== C_FLUSH) begin
      bad++; $display("FAIL memwait_release got=%b want=%b", ctrl, C_FLUSH);
    end
    tick();
    idle();
    #1;
    total++;
    if (stall_count !== 4'd3 || flush_count !== 4'd1 || mem_timeout !== 1'b0) begin
      bad++; $display("FAIL memwait_cnt got stall=%0d flush=%0d to=%b want 3 1 0",
                      stall_count, flush_count, mem_timeout);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < int'(TO); i++) begin
      #1;
      total++;
      if (ctrl !== C_FREEZE || mem_timeout !== 1'b0) begin
        bad++; $display("FAIL timeout_wait[%0d] got ctrl=%b to=%b want %b 0",
                        i, ctrl, mem_timeout, C_FREEZE);
      end
      tick();
    end
    // In ERR: nothing moves, even with the memory ready and a taken branch.
    mem_ready = 1'b1; mem_branch = 2'd3;
    #1;
    total++;
    if (mem_timeout !== 1'b1 || ctrl !== C_FREEZE || stall_count !== 4'd4) begin
      bad++; $display("FAIL timeout_err got to=%b ctrl=%b stall=%0d want 1 %b 4",
                      mem_timeout, ctrl, stall_count, C_FREEZE);
    end
    tick();
    #1;
    total++;
    if (mem_timeout !== 1'b1 || flush_count !== 4'd0 || stall_count !== 4'd4) begin
      bad++; $display("FAIL timeout_sticky got to=%b flush=%0d stall=%0d want 1 0 4",
                      mem_timeout, flush_count, stall_count);
    end
    do_reset();
    #1;
    total++;
    if (mem_timeout !== 1'b0 || ctrl !== C_IDLE) begin
      bad++; $display("FAIL timeout_clear got to=%b ctrl=%b want 0 %b",
                      mem_timeout, ctrl, C_IDLE);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
    for (int i = 0; i < 20; i++) tick();
    idle();
    #1;
    total++;
    if (stall_count !== 4'd15) begin
      bad++; $display("FAIL stall_saturate got=%0d want=15", stall_count);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst_n       = ($urandom_range(63) != 0);
      id_rs       = 5'($urandom_range(3));
      id_rt       = 5'($urandom_range(3));
      ex_rd       = 5'($urandom_range(3));
      id_uses_rt  = 1'($urandom_range(1));
      ex_mem_read = 1'($urandom_range(1));
      mem_branch  = 2'($urandom_range(3));
      mem_zero    = 1'($urandom_range(1));
      mem_req     = 1'($urandom_range(1));
      mem_ready   = ($urandom_range(3) != 0);
      #1;
      total++;
      if (ctrl !== exp_ctrl()) begin
        bad++; $display("FAIL rand_ctrl[%0d] got=%b want=%b", n, ctrl, exp_ctrl());
      end
      total++;
      if (stall_count !== CW'(m_stall) || flush_count !== CW'(m_flush) ||
          mem_timeout !== 1'(m_err)) begin
        bad++; $display("FAIL rand_regs[%0d] got stall=%0d flush=%0d to=%b want %0d %0d %0d",
                        n, stall_count, flush_count, mem_timeout, m_stall, m_flush, m_err);
      end
      tick();
    end
  endtask

  initial begin
    m_err = 0; m_run = 0; m_stall = 0; m_flush = 0;
    idle();
    rst_n = 1'b0;
    test_reset();
    test_loaduse();
    test_branch();
    test_memwait();
    test_timeout();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
